// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: FSM state encoding and saturating counter rules.
package bp_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned CTR_MAX_W = 8;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic ctr_t ctr_max(input int unsigned ctr_w);
    return ctr_t'((32'd1 << ctr_w) - 32'd1);
  endfunction

  function automatic ctr_t sat_inc(input ctr_t ctr, input int unsigned ctr_w);
    return (ctr >= ctr_max(ctr_w)) ? ctr_max(ctr_w) : ctr + 8'd1;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t ctr);
    return (ctr == 8'd0) ? 8'd0 : ctr - 8'd1;
  endfunction

endpackage

// File: rtl/pht_predictor_if.sv
// Fetch/execute side bus of the pattern history table predictor.
interface pht_predictor_if #(
  parameter int unsigned PC_W = 32
);
  logic            req_valid;
  logic [PC_W-1:0] req_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            ready;

  modport master (
    output req_valid, req_pc, upd_valid, upd_pc, upd_taken,
    input  pred_valid, pred_taken, ready
  );

  modport slave (
    input  req_valid, req_pc, upd_valid, upd_pc, upd_taken,
    output pred_valid, pred_taken, ready
  );
endinterface

// File: rtl/pht_ctr_upd.sv
// Combinational saturating counter next-value: increments on taken, decrements otherwise.
module pht_ctr_upd
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_nxt_o
);

  ctr_t ctr_ext_s;
  ctr_t nxt_ext_s;

  // Saturating step in the package-wide counter width, then narrowed back.
  always_comb begin
    ctr_ext_s = ctr_t'(ctr_i);
    if (taken_i) begin
      nxt_ext_s = sat_inc(ctr_ext_s, CTR_W);
    end else begin
      nxt_ext_s = sat_dec(ctr_ext_s);
    end
    ctr_nxt_o = CTR_W'(nxt_ext_s);
  end

endmodule

// File: rtl/pht_predictor.sv
// Pattern history table branch predictor with init sweep; define PHT_GSHARE_EN to XOR
// the table index with a global history register (gshare), otherwise pure bimodal.
module pht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned PC_LSB   = 2,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned INIT_CTR = 2**CTR_W-1,
  parameter int unsigned HIST_W   = IDX_W
) (
  input  logic clk,
  input  logic rst_n,
  pht_predictor_if.slave bus
);

  localparam int unsigned DEPTH = 2**IDX_W;

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [CTR_W-1:0] table_q [DEPTH];
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] req_idx_s, upd_idx_s;
  logic [IDX_W-1:0] ridx_s, uidx_s;
  logic [CTR_W-1:0] ctr_nxt_s;
  logic             run_s;
  logic             unused_pc_s;

  assign run_s       = (state_q == ST_RUN);
  assign req_idx_s   = bus.req_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign upd_idx_s   = bus.upd_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign unused_pc_s = ^{bus.req_pc, bus.upd_pc};

`ifdef PHT_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // History shifts in each resolved outcome; held clear while the table is swept.
  always_comb begin
    if (state_q == ST_INIT) begin
      ghr_d = '0;
    end else if (bus.upd_valid) begin
      ghr_d = HIST_W'({ghr_q, bus.upd_taken});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ridx_s = req_idx_s ^ IDX_W'(ghr_q);
  assign uidx_s = upd_idx_s ^ IDX_W'(ghr_q);
`else
  localparam int unsigned HIST_W_UNUSED = HIST_W;
  assign ridx_s = req_idx_s;
  assign uidx_s = upd_idx_s;
`endif

  pht_ctr_upd #(
    .CTR_W (CTR_W)
  ) u_ctr_upd (
    .ctr_i     (table_q[uidx_s]),
    .taken_i   (bus.upd_taken),
    .ctr_nxt_o (ctr_nxt_s)
  );

  // FSM next state, sweep counter and prediction register inputs.
  always_comb begin
    state_d      = state_q;
    sweep_d      = '0;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        if (bus.req_valid) begin
          pred_valid_d = 1'b1;
          pred_taken_d = table_q[ridx_s][CTR_W-1];
        end else begin
          pred_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State, sweep index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Table storage: init sweep owns the write port, then resolved updates do.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      table_q[sweep_q] <= CTR_W'(INIT_CTR);
    end else if (bus.upd_valid) begin
      table_q[uidx_s] <= ctr_nxt_s;
    end
  end

  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.ready      = run_s;

endmodule

// File: tb/tb_pht_predictor.sv
// Scoreboard bench for pht_predictor: stimulus pushes expected predictions, a monitor pops them.
module tb_pht_predictor;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  bit   exp_q[$];

  pht_predictor_if #(.PC_W(32)) bus ();

  pht_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented prediction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.pred_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_pred: got pred_valid=1 expected no prediction at %0t", $time);
      end else begin
        chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic req(input logic [31:0] pc, input bit exp);
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken, input int n);
    for (int i = 0; i < n; i++) begin
      bus.upd_valid = 1'b1;
      bus.upd_pc    = pc;
      bus.upd_taken = taken;
      @(negedge clk);
    end
    bus.upd_valid = 1'b0;
  endtask

  // Release reset with traffic held active; all of it must be ignored during the sweep.
  task automatic init_sweep();
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h0000_0100;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h0000_0100;
    bus.upd_taken = 1'b0;
    rst_n         = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("ready_sweep", {31'd0, bus.ready}, (k == 64) ? 32'd1 : 32'd0);
      chk("pred_valid_init", {31'd0, bus.pred_valid}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pc    = 32'd0;
    bus.upd_valid = 1'b0;
    bus.upd_pc    = 32'd0;
    bus.upd_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
    chk("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    init_sweep();

    // Default counters are strongly taken.
    req(32'h0000_0100, 1'b1);

`ifdef PHT_GSHARE_EN
    // Entry 5 trained down with GHR=0, then T,N,T leaves GHR=0b000101.
    upd(32'h0000_0014, 1'b0, 2);
    upd(32'h0000_0000, 1'b1, 1);
    upd(32'h0000_0000, 1'b0, 1);
    upd(32'h0000_0000, 1'b1, 1);
    req(32'h0000_0000, 1'b0);
    req(32'h0000_0014, 1'b1);
    req(32'h0000_0004, 1'b1);
`else
    // Training and low saturation on index 0.
    upd(32'h0000_0100, 1'b0, 2);
    req(32'h0000_0100, 1'b0);
    upd(32'h0000_0100, 1'b0, 3);
    req(32'h0000_0100, 1'b0);
    upd(32'h0000_0100, 1'b1, 1);
    req(32'h0000_0100, 1'b0);
    upd(32'h0000_0100, 1'b1, 1);
    req(32'h0000_0100, 1'b1);

    // High saturation on fresh index 2.
    upd(32'h0000_0008, 1'b1, 5);
    req(32'h0000_0008, 1'b1);
    upd(32'h0000_0008, 1'b0, 1);
    req(32'h0000_0008, 1'b1);
    upd(32'h0000_0008, 1'b0, 1);
    req(32'h0000_0008, 1'b0);

    // Same-cycle req and update on index 0 (counter 2): read-before-write.
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h0000_0200;
    bus.upd_taken = 1'b0;
    req(32'h0000_0200, 1'b1);
    bus.upd_valid = 1'b0;
    req(32'h0000_0200, 1'b0);

    // Aliasing on index 1, back-to-back requests, upper PC bits ignored.
    upd(32'h0000_0004, 1'b0, 1);
    upd(32'h0000_0104, 1'b0, 1);
    req(32'h0000_0104, 1'b0);
    req(32'h0000_0004, 1'b0);
    req(32'hFFFF_0004, 1'b0);
`endif

    // Mid-RUN reset wipes all training.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
    @(negedge clk);
    init_sweep();
    req(32'h0000_0004, 1'b1);
    req(32'h0000_0100, 1'b1);
    req(32'h0000_0008, 1'b1);
    req(32'h0000_0014, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("pending_preds", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
